// File: rtl/slt2_if.sv
// Operand/result bundle for the registered shift-left unit.
// master drives the operand side, slave (the shifter) drives the result side.
interface slt2_if #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 2
) ();
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic [SHIFT-1:0] lost_bits;
    logic             ovf;

    modport master (
        output in_valid, a,
        input  out_valid, y, lost_bits, ovf
    );

    modport slave (
        input  in_valid, a,
        output out_valid, y, lost_bits, ovf
    );
endinterface

// File: rtl/slt2.sv
// Registered shift-left-by-SHIFT: word offset to byte offset for branch targets.
// Reports the bits pushed out and whether the signed value no longer fits.
module slt2 #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 2
) (
    input  logic  clk,
    input  logic  reset,
    slt2_if.slave bus
);
    logic [SHIFT:0] top_bits;
    logic           ovf_nxt;

    // The kept sign bit plus every bit shifted out must agree for the result to fit.
    assign top_bits = bus.a[WIDTH-1 -: SHIFT+1];
    assign ovf_nxt  = !((top_bits == '0) || (top_bits == '1));

    // Data registers only load under in_valid, so an X operand while idle never reaches y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.lost_bits <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y         <= {bus.a[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
                bus.lost_bits <= bus.a[WIDTH-1 -: SHIFT];
                bus.ovf       <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_slt2.sv
// Scoreboard bench for slt2: stimulus pushes expected results, a negedge monitor pops and compares.
// Reference is arithmetic (multiply by 2**SHIFT, divide for lost bits, signed range test for ovf).
module tb_slt2;
    localparam int W = 32;
    localparam int S = 2;

    typedef struct packed {
        logic [W-1:0] y;
        logic [S-1:0] lost;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    slt2_if #(.WIDTH(W), .SHIFT(S)) bus ();
    slt2 #(.WIDTH(W), .SHIFT(S)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t q[$];
    exp_t hold = '0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a);
        exp_t   e;
        longint ua, sa, p, hi, lo;
        ua     = longint'(a);
        sa     = longint'($signed(a));
        e.y    = W'(ua * (longint'(1) << S));
        e.lost = S'(ua / (longint'(1) << (W - S)));
        p      = sa * (longint'(1) << S);
        hi     = (longint'(1) << (W - 1)) - 1;
        lo     = -(longint'(1) << (W - 1));
        e.ovf  = (p > hi) || (p < lo);
        return e;
    endfunction

    // Monitor: every valid output pops one expectation; idle cycles must hold the last result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("y", 64'(bus.y), 64'(e.y));
                    chk("lost_bits", 64'(bus.lost_bits), 64'(e.lost));
                    chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                    hold = e;
                end
            end else begin
                chk("hold_y", 64'(bus.y), 64'(hold.y));
                chk("hold_lost", 64'(bus.lost_bits), 64'(hold.lost));
                chk("hold_ovf", 64'(bus.ovf), 64'(hold.ovf));
            end
        end
    end

    task automatic send_exp(input logic [W-1:0] a, input exp_t e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        q.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] a);
        send_exp(a, model(a));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 'x;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_y"}, 64'(bus.y), 64'd0);
        chk({tag, "_lost"}, 64'(bus.lost_bits), 64'd0);
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    logic [W-1:0] corners [6] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                 32'h2000_0000, 32'hE000_0000, 32'hDFFF_FFFF};

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_cleared("reset");
        #1 reset = 1'b0;

        // Directed vectors with hand-computed results
        send_exp(32'h1234_5678, '{y: 32'h48D1_59E0, lost: 2'b00, ovf: 1'b0});
        send_exp(32'hFEDC_BA98, '{y: 32'hFB72_EA60, lost: 2'b11, ovf: 1'b0});
        send_exp(32'h4000_0000, '{y: 32'h0000_0000, lost: 2'b01, ovf: 1'b1});
        send_exp(32'h8000_0000, '{y: 32'h0000_0000, lost: 2'b10, ovf: 1'b1});
        idle();
        send_exp(32'd1, '{y: 32'd4,  lost: 2'b00, ovf: 1'b0});
        send_exp(32'd2, '{y: 32'd8,  lost: 2'b00, ovf: 1'b0});
        send_exp(32'd3, '{y: 32'd12, lost: 2'b00, ovf: 1'b0});
        repeat (3) idle();

        // Mid-stream async reset with a non-zero result on the outputs
        send(32'hFFFF_FFF0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.a = 'x;
        chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk_cleared("async_reset");
        q.delete();
        hold = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        send_exp(32'h0000_0005, '{y: 32'h0000_0014, lost: 2'b00, ovf: 1'b0});
        idle();

        // Randomized traffic, biased toward sign/overflow boundaries
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) < 7) begin
                if ($urandom_range(3) == 0) send(corners[$urandom_range(5)]);
                else send($urandom);
            end else begin
                idle();
            end
        end

        repeat (3) idle();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slt2.md
Name: slt2

Overview:
- Registered shift-left-by-SHIFT unit (default 32-bit, shift 2) for the MIPS single-cycle datapath.
- Converts a sign-extended word offset into a byte offset for branch-target computation.
- Registers the shifted word and reports the bits shifted out, plus a signed-overflow flag.
- One clock domain; result appears one cycle after a valid input.

Parameters:
- WIDTH, 32, data width of a and y (must be > SHIFT).
- SHIFT, 2, fixed left-shift amount in bits (1 ≤ SHIFT < WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a is sampled on this clock edge when high.
- a  input  WIDTH  operand to shift.
- out_valid  output  1  high for exactly one cycle per accepted input.
- y  output  WIDTH  registered result: a << SHIFT, low SHIFT bits zero.
- lost_bits  output  SHIFT  registered a[WIDTH-1 : WIDTH-SHIFT] (bits shifted out).
- ovf  output  1  registered signed-overflow flag.

Behaviour:
- Reset: one clock, asynchronous, active-high.
  - While reset is high, y=0, lost_bits=0, ovf=0, out_valid=0, immediately and independent of clk.
  - Deassertion takes effect at the next rising edge.
- On a rising edge with in_valid=1 (reset low):
  - y <= {a[WIDTH-SHIFT-1:0], SHIFT'b0}.
  - lost_bits <= a[WIDTH-1:WIDTH-SHIFT].
  - ovf <= 1 unless bits a[WIDTH-1 : WIDTH-SHIFT-1] are all equal; otherwise 0. Equal bits mean the signed value fits after shifting.
  - out_valid <= 1.
- On a rising edge with in_valid=0:
  - y, lost_bits and ovf hold their previous values.
  - out_valid <= 0.
- Latency is 1 cycle and throughput is 1 per cycle. Back-to-back valid inputs each produce a result on consecutive cycles.
- There is no back-pressure; the output is never stalled.
- The shift is purely logical. Bit order is preserved and no rotation occurs; vacated LSBs are always 0.
- Reset asserted mid-stream: the in-flight result is discarded and all outputs clear at once. The first valid input after release behaves normally.
- X on a when in_valid=0 must not propagate into the outputs.

Test Plan:
- Reset asserted asynchronously mid-cycle with outputs non-zero -> y=0, lost_bits=0, ovf=0 and out_valid=0 immediately, before the next clk edge.
- a=32'h12345678, in_valid=1 -> next cycle y=32'h48D159E0, lost_bits=2'b00, ovf=0, out_valid=1.
- a=32'hFEDCBA98, in_valid=1 -> next cycle y=32'hFB72EA60, lost_bits=2'b11, ovf=0.
- a=32'h40000000 -> y=32'h00000000, lost_bits=2'b01, ovf=1. Then a=32'h80000000 -> y=0, lost_bits=2'b10, ovf=1.
- Back-to-back: a=1, 2, 3 on consecutive cycles -> y=4, 8, 12 on the following consecutive cycles. Then in_valid=0 -> out_valid=0 and y holds 12.
